ram_sdp: RTL and testbench

RAM_SDP -- requirements
Module: ram_sdp

---
 rtl/ram_sdp.sv | 163 ++++++++++++++++
 tb/tb_ram_sdp.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port with byte enables, one read port with 1- or 2-cycle latency.
// Define RAM_CLEAR_EN to build in the clear engine that zeroes the array after reset and on clr.
module ram_sdp #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int OUT_REG   = 0,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W/8-1:0] w_be,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic              clr,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  output logic              busy
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy_s;
  logic              w_acc_s;
  logic              r_acc_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] r_data_q;
  logic              r_valid_q;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NB-1:0]     be);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_w[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_w[8*b +: 8];
      end
    end
    return res;
  endfunction

`ifdef RAM_CLEAR_EN
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;

  // Clear engine: reset lands in CLEAR so the array is always zeroed after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (&cnt_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy_s     = (state_q == CLEAR);
  assign clr_we_s   = busy_s;
  assign clr_addr_s = cnt_q;
`else
  logic unused_clr_s;
  assign unused_clr_s = clr;
  assign busy_s       = 1'b0;
  assign clr_we_s     = 1'b0;
  assign clr_addr_s   = '0;
`endif

  assign w_acc_s = w_en & ~busy_s;
  assign r_acc_s = r_en & ~busy_s;

  // Array write port: clear engine and user writes are mutually exclusive via busy.
  always_ff @(posedge clk) begin
    if (clr_we_s) begin
      mem[clr_addr_s] <= '0;
    end else if (w_acc_s) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) begin
          mem[w_addr][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  // Same-edge collision returns the write-merged word.
  always_comb begin
    rd_word_s = mem[r_addr];
    if (w_acc_s && (w_addr == r_addr)) begin
      rd_word_s = merge_bytes(mem[r_addr], w_data, w_be);
    end else begin
      rd_word_s = mem[r_addr];
    end
  end

  if (OUT_REG == 0) begin : g_lat1
    // Single read stage; data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= r_acc_s;
        if (r_acc_s) begin
          r_data_q <= rd_word_s;
        end
      end
    end
  end else begin : g_lat2
    logic              p_valid_q;
    logic [DATA_W-1:0] p_data_q;

    // Two read stages; the output register only loads when its stage is valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_valid_q <= 1'b0;
        p_data_q  <= '0;
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        p_valid_q <= r_acc_s;
        if (r_acc_s) begin
          p_data_q <= rd_word_s;
        end
        r_valid_q <= p_valid_q;
        if (p_valid_q) begin
          r_data_q <= p_data_q;
        end
      end
    end
  end

  assign r_data  = r_data_q;
  assign r_valid = r_valid_q;
  assign busy    = busy_s;

endmodule

// File: tb/tb_ram_sdp.sv
// Randomized bench for ram_sdp: both latencies side by side against an array-based reference.
module tb_ram_sdp;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int NB    = 4;
`ifdef RAM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          w_en  = 1'b0;
  logic          r_en  = 1'b0;
  logic          clr   = 1'b0;
  logic [AW-1:0] w_addr = '0;
  logic [AW-1:0] r_addr = '0;
  logic [DW-1:0] w_data = '0;
  logic [NB-1:0] w_be   = '0;
  logic [DW-1:0] r_data0, r_data1;
  logic          r_valid0, r_valid1, busy0, busy1;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference: word array, a clear countdown, and expected output state per latency.
  logic [DW-1:0] ref_mem [DEPTH];
  int            clr_left = 0;
  bit            p_v = 1'b0;
  logic [DW-1:0] p_d = '0;
  bit            e_v0 = 1'b0, e_v1 = 1'b0;
  logic [DW-1:0] e_d0 = '0, e_d1 = '0;
  bit            filled = CLR_EN;

  always #5 clk = ~clk;

  ram_sdp #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .r_en(r_en), .r_addr(r_addr), .clr(clr), .r_data(r_data0), .r_valid(r_valid0), .busy(busy0)
  );

  ram_sdp #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .w_en(w_en), .w_addr(w_addr), .w_data(w_data), .w_be(w_be),
    .r_en(r_en), .r_addr(r_addr), .clr(clr), .r_data(r_data1), .r_valid(r_valid1), .busy(busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [NB-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  task automatic check_outputs();
    check_eq("valid_lat1", 32'(r_valid0), 32'(e_v0));
    check_eq("data_lat1",  r_data0, e_d0);
    check_eq("valid_lat2", 32'(r_valid1), 32'(e_v1));
    check_eq("data_lat2",  r_data1, e_d1);
    check_eq("busy_lat1",  32'(busy0), 32'(clr_left > 0));
    check_eq("busy_lat2",  32'(busy1), 32'(clr_left > 0));
  endtask

  // One clock of stimulus; reference updated from the pre-edge state, then outputs checked.
  task automatic step(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input bit re, input logic [AW-1:0] ra, input bit c);
    bit            busy_m;
    logic [DW-1:0] rd;
    w_en = we; w_addr = wa; w_data = wd; w_be = be;
    r_en = re; r_addr = ra; clr = c;
    busy_m = (clr_left > 0);
    rd = ref_mem[ra];
    if (we && !busy_m && wa == ra) rd = merge(rd, wd, be);
    @(posedge clk);
    #1;
    e_v1 = p_v;
    if (p_v) e_d1 = p_d;
    p_v = re && !busy_m;
    if (p_v) p_d = rd;
    e_v0 = re && !busy_m;
    if (e_v0) e_d0 = rd;
    if (we && !busy_m) ref_mem[wa] = merge(ref_mem[wa], wd, be);
    if (busy_m) begin
      clr_left--;
    end else if (c && CLR_EN) begin
      clr_left = DEPTH;
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    end
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; w_en = 1'b0; r_en = 1'b0; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid_lat1", 32'(r_valid0), 32'd0);
    check_eq("rst_valid_lat2", 32'(r_valid1), 32'd0);
    check_eq("rst_data_lat1",  r_data0, 32'd0);
    check_eq("rst_data_lat2",  r_data1, 32'd0);
    check_eq("rst_busy",       32'(busy0), 32'(CLR_EN));
    rst_n = 1'b1;
    p_v = 1'b0; p_d = '0;
    e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = '0; e_d1 = '0;
    clr_left = CLR_EN ? DEPTH : 0;
    if (CLR_EN) begin
      for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    end
  endtask

  // Counts busy-high samples while hammering the ports; accesses during busy must be dropped.
  task automatic busy_window(input string tag);
    int cnt;
    cnt = int'(busy0);
    for (int i = 0; i < 20; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'hf,
           filled && 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0);
      cnt += int'(busy0);
    end
    check_eq(tag, 32'(cnt), CLR_EN ? 32'd16 : 32'd0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) step(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
    idle();
    idle();
  endtask

  initial begin
    #2;
    do_reset();
    busy_window("busy_after_reset");

    for (int a = 0; a < DEPTH; a++) step(1'b1, 4'(a), $urandom, 4'hf, 1'b0, '0, 1'b0);
    filled = 1'b1;
    read_all();

    // Byte-enable merge.
    step(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0, '0, 1'b0);
    step(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
    check_eq("byte_we_lat1", r_data0, 32'hAA22CC44);
    idle();
    check_eq("byte_we_lat2", r_data1, 32'hAA22CC44);
    step(1'b1, 4'd5, 32'h12345678, 4'b0000, 1'b1, 4'd5, 1'b0);
    idle();

    // Same-edge write/read collision.
    step(1'b1, 4'd7, 32'h0, 4'hf, 1'b0, '0, 1'b0);
    step(1'b1, 4'd7, 32'hFFFFFF5A, 4'b0001, 1'b1, 4'd7, 1'b0);
    check_eq("collide_lat1", r_data0, 32'h0000005A);
    idle();
    check_eq("collide_lat2", r_data1, 32'h0000005A);

    // Three back-to-back reads.
    for (int a = 0; a < 3; a++) step(1'b0, '0, '0, '0, 1'b1, 4'(a), 1'b0);
    idle();
    idle();

    // clr pulse, then reset in the middle of a clear and in the middle of reads.
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
    busy_window("busy_after_clr");
    read_all();
    do_reset();
    repeat (5) idle();
    do_reset();
    busy_window("busy_after_midclear_reset");
    read_all();
    step(1'b0, '0, '0, '0, 1'b1, 4'd1, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
    do_reset();
    busy_window("busy_after_midread_reset");

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 39) == 0);
    end
    read_all();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
